// File: rtl/debug_uart_dump.sv
// Snapshots six 16-bit debug words on trigger and sends them as one 31-char hex text line over 8N1 UART.
// Start bit appears the cycle after trigger is sampled in IDLE; triggers outside IDLE are dropped.
module debug_uart_dump #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic [15:0] in5,
  input  logic [15:0] in6,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [4:0]       char_q, char_d;
  logic [5:0][15:0] snap_q, snap_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             baud_done;
  logic [7:0]       char_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Char index 5w+p carries nibble p (MS first) of word w; gaps are space, then CR LF.
  function automatic logic [7:0] frame_char(input logic [5:0][15:0] snap, input logic [4:0] idx);
    logic [7:0] c;
    case (idx)
      5'd29:   c = 8'h0D;
      5'd30:   c = 8'h0A;
      default: c = 8'h20;
    endcase
    for (int w = 0; w < 6; w++) begin
      for (int p = 0; p < 4; p++) begin
        if (idx == 5'(5 * w + p)) c = hex_ascii(snap[3'(w)][4'(4 * (3 - p)) +: 4]);
      end
    end
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    char_d    = char_q;
    snap_d    = snap_q;
    baud_done = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        if (trigger) begin
          snap_d  = {in6, in5, in4, in3, in2, in1};
          char_d  = 5'd0;
          baud_d  = 16'd0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = 16'd0;
          if (char_q == 5'd30) begin
            state_d = IDLE;
          end else begin
            char_d  = char_q + 5'd1;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
    endcase

    // Outputs are decoded from the next state so tx/busy come straight from flops.
    char_byte = frame_char(snap_d, char_d);
    busy_d    = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = char_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    snap_q <= snap_d;
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      char_q  <= 5'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
